featuremap_pad_writer: RTL

Producer side of the per-channel feature-map FIFOs feeding an 8-input-channel conv layer. Takes the 8 parallel channel outputs of the previous layer as a raster stream of WIDTH×WIDTH pixels, wraps every frame in a one-pixel zero border, and writes (WIDTH+2)×(WIDTH+2) words per channel into 8 FIFOs with a shared write request. Upstream is throttled with a ready signal whenever a border word is being generated or any FIFO is nearly full.

---
 rtl/featuremap_pad_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/featuremap_pad_writer.sv
`default_nettype none
// ============================================================================
//  Module   : featuremap_pad_writer
//  Purpose  : Producer for the 8 per-channel feature-map FIFOs. Accepts a
//             raster stream of WIDTH x WIDTH pixels on 8 parallel channels,
//             adds a one-pixel zero border and writes (WIDTH+2)^2 words per
//             channel. All 8 FIFOs share one write strobe.
//  Ports    : clk, rst (sync, active-high)
//             data_in_channel0..7, valid_in  -> upstream pixel stream
//             ready_in                       <- pixel taken on valid & ready
//             fifo_afull0..7                 -> FIFO k has <=1 free entry
//             data_out_channel0..7, wrreq    <- registered FIFO write port
//             frame_done                     <- pulse with last frame write
//  Revision : 1.0  initial release
// ============================================================================
module featuremap_pad_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in_channel0,
  input  logic [DATA_WIDTH-1:0] data_in_channel1,
  input  logic [DATA_WIDTH-1:0] data_in_channel2,
  input  logic [DATA_WIDTH-1:0] data_in_channel3,
  input  logic [DATA_WIDTH-1:0] data_in_channel4,
  input  logic [DATA_WIDTH-1:0] data_in_channel5,
  input  logic [DATA_WIDTH-1:0] data_in_channel6,
  input  logic [DATA_WIDTH-1:0] data_in_channel7,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  fifo_afull0,
  input  logic                  fifo_afull1,
  input  logic                  fifo_afull2,
  input  logic                  fifo_afull3,
  input  logic                  fifo_afull4,
  input  logic                  fifo_afull5,
  input  logic                  fifo_afull6,
  input  logic                  fifo_afull7,
  output logic [DATA_WIDTH-1:0] data_out_channel0,
  output logic [DATA_WIDTH-1:0] data_out_channel1,
  output logic [DATA_WIDTH-1:0] data_out_channel2,
  output logic [DATA_WIDTH-1:0] data_out_channel3,
  output logic [DATA_WIDTH-1:0] data_out_channel4,
  output logic [DATA_WIDTH-1:0] data_out_channel5,
  output logic [DATA_WIDTH-1:0] data_out_channel6,
  output logic [DATA_WIDTH-1:0] data_out_channel7,
  output logic                  wrreq,
  output logic                  frame_done
);

  localparam int              POS_W     = $clog2(WIDTH + 2);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(WIDTH + 1);
  localparam logic [POS_W-1:0] LAST_DATA = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  typedef enum logic [2:0] {
    PAD_TOP    = 3'd0,
    ROW_LEFT   = 3'd1,
    ROW_DATA   = 3'd2,
    ROW_RIGHT  = 3'd3,
    PAD_BOTTOM = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [POS_W-1:0]       row_q, row_d;
  logic [POS_W-1:0]       col_q, col_d;
  logic                   wrreq_q, wrreq_d;
  logic                   frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0]  data_q [8];
  logic [DATA_WIDTH-1:0]  data_d [8];
  logic [DATA_WIDTH-1:0]  din    [8];

  logic stall;
  logic in_data;
  logic write;

  assign din[0] = data_in_channel0;
  assign din[1] = data_in_channel1;
  assign din[2] = data_in_channel2;
  assign din[3] = data_in_channel3;
  assign din[4] = data_in_channel4;
  assign din[5] = data_in_channel5;
  assign din[6] = data_in_channel6;
  assign din[7] = data_in_channel7;

  assign stall = fifo_afull0 | fifo_afull1 | fifo_afull2 | fifo_afull3 |
                 fifo_afull4 | fifo_afull5 | fifo_afull6 | fifo_afull7;

  assign in_data = (state_q == ROW_DATA);
  // Pad cells never wait for upstream; data cells need a valid pixel.
  assign write    = ~rst & ~stall & (in_data ? valid_in : 1'b1);
  assign ready_in = ~rst & ~stall & in_data;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    wrreq_d      = write;
    frame_done_d = write & (state_q == PAD_BOTTOM) & (col_q == LAST_POS);
    for (int k = 0; k < 8; k++) begin
      data_d[k] = (write & in_data) ? din[k] : '0;
    end

    if (write) begin
      if (col_q == LAST_POS) begin
        col_d = '0;
        row_d = (row_q == LAST_POS) ? '0 : row_q + POS_ONE;
      end else begin
        col_d = col_q + POS_ONE;
      end

      case (state_q)
        PAD_TOP:    if (col_q == LAST_POS) state_d = ROW_LEFT;
        ROW_LEFT:   state_d = ROW_DATA;
        ROW_DATA:   if (col_q == LAST_DATA) state_d = ROW_RIGHT;
        // row_q is the row just finishing; the last image row goes to bottom pad.
        ROW_RIGHT:  state_d = (row_q < LAST_DATA) ? ROW_LEFT : PAD_BOTTOM;
        PAD_BOTTOM: if (col_q == LAST_POS) state_d = PAD_TOP;
        default:    state_d = PAD_TOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PAD_TOP;
      row_q        <= '0;
      col_q        <= '0;
      wrreq_q      <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wrreq_q      <= wrreq_d;
      frame_done_q <= frame_done_d;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign wrreq             = wrreq_q;
  assign frame_done        = frame_done_q;
  assign data_out_channel0 = data_q[0];
  assign data_out_channel1 = data_q[1];
  assign data_out_channel2 = data_q[2];
  assign data_out_channel3 = data_q[3];
  assign data_out_channel4 = data_q[4];
  assign data_out_channel5 = data_q[5];
  assign data_out_channel6 = data_q[6];
  assign data_out_channel7 = data_q[7];

endmodule
`default_nettype wire
